// File: rtl/decode_stage.sv
// decode_stage
//   Registered, handshaked RV32I/RV64I decode stage between fetch and
//   register-read. The instruction is decoded combinationally at the input
//   and the decoded entry is captured on accept. A main entry drives the
//   outputs, and one skid entry absorbs the cycle of latency on in_ready.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   flush           synchronous flush, drops every buffered entry
//   in_valid/ready  input handshake; in_ready is a register output
//   in_instr, in_pc raw instruction and its PC
//   out_valid/ready output handshake
//   out_pc          PC of the presented entry
//   out_opcode..out_funct7  raw bit slices of the instruction
//   out_imm         sign-extended immediate (XLEN bits)
//   out_fmt         R=0 I=1 S=2 B=3 U=4 J=5 unknown=7
//   out_illegal     not a legal base instruction (0 when CHECK_ILLEGAL=0)
module decode_stage #(
  parameter int XLEN          = 32,
  parameter int PC_WIDTH      = 32,
  parameter int CHECK_ILLEGAL = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [6:0]          out_opcode,
  output logic [4:0]          out_rd,
  output logic [2:0]          out_funct3,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [6:0]          out_funct7,
  output logic [XLEN-1:0]     out_imm,
  output logic [2:0]          out_fmt,
  output logic                out_illegal
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_OP32   = 7'h3B;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMM32  = 7'h1B;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // Everything the output side needs; the raw fields are slices of instr.
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
    logic [XLEN-1:0]     imm;
    logic [2:0]          fmt;
    logic                ill;
  } entry_t;

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [2:0]  w_fmt;
  logic [31:0] w_imm32;
  logic        w_ill_raw;
  logic        w_ill;
  entry_t      w_new;

  logic   r_main_v;
  logic   r_skid_v;
  entry_t r_main;
  entry_t r_skid;
  logic   w_acc;
  logic   w_xfer;

  // ---------------------------------------------------------------- decode
  always_comb begin
    w_op = in_instr[6:0];
    w_f3 = in_instr[14:12];
    w_f7 = in_instr[31:25];

    case (w_op)
      OP_OP, OP_OP32:                         w_fmt = FMT_R;
      OP_IMM, OP_IMM32, OP_LOAD, OP_JALR,
      OP_SYSTEM, OP_FENCE:                    w_fmt = FMT_I;
      OP_STORE:                               w_fmt = FMT_S;
      OP_BRANCH:                              w_fmt = FMT_B;
      OP_LUI, OP_AUIPC:                       w_fmt = FMT_U;
      OP_JAL:                                 w_fmt = FMT_J;
      default:                                w_fmt = FMT_X;
    endcase

    case (w_fmt)
      FMT_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   w_imm32 = {in_instr[31:12], 12'b0};
      FMT_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase

    w_ill_raw = 1'b0;
    if (in_instr[1:0] != 2'b11)
      w_ill_raw = 1'b1;
    if (w_fmt == FMT_X)
      w_ill_raw = 1'b1;
    if ((w_fmt == FMT_R) && (w_f7 != 7'h00) && (w_f7 != 7'h20) && (w_f7 != 7'h01))
      w_ill_raw = 1'b1;
    // Shift-immediate encodings: upper six bits select logical/arithmetic.
    if ((w_op == OP_IMM) && (w_f3 == 3'd1) && (in_instr[31:26] != 6'h00))
      w_ill_raw = 1'b1;
    if ((w_op == OP_IMM) && (w_f3 == 3'd5) &&
        (in_instr[31:26] != 6'h00) && (in_instr[31:26] != 6'h10))
      w_ill_raw = 1'b1;
    if (((w_op == OP_IMM32) || (w_op == OP_OP32)) && (XLEN == 32))
      w_ill_raw = 1'b1;
    if ((in_instr == 32'h0000_0000) || (in_instr == 32'hFFFF_FFFF))
      w_ill_raw = 1'b1;

    w_ill = (CHECK_ILLEGAL != 0) ? w_ill_raw : 1'b0;

    w_new.pc    = in_pc;
    w_new.instr = in_instr;
    w_new.imm   = XLEN'($signed(w_imm32));
    w_new.fmt   = w_fmt;
    w_new.ill   = w_ill;
  end

  // ------------------------------------------------------- main + skid
  assign w_acc  = in_valid && !r_skid_v;
  assign w_xfer = r_main_v && out_ready;

  // The skid can only fill while main holds and is not draining, so an
  // accept never coincides with a skid->main move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= '0;
      r_skid   <= '0;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_xfer) begin
      if (r_skid_v) begin
        r_main   <= r_skid;
        r_skid_v <= 1'b0;
      end else if (w_acc) begin
        r_main   <= w_new;
      end else begin
        r_main_v <= 1'b0;
      end
    end else if (!r_main_v) begin
      if (w_acc) begin
        r_main   <= w_new;
        r_main_v <= 1'b1;
      end
    end else if (w_acc) begin
      r_skid   <= w_new;
      r_skid_v <= 1'b1;
    end
  end

  assign in_ready    = !r_skid_v;
  assign out_valid   = r_main_v;
  assign out_pc      = r_main.pc;
  assign out_opcode  = r_main.instr[6:0];
  assign out_rd      = r_main.instr[11:7];
  assign out_funct3  = r_main.instr[14:12];
  assign out_rs1     = r_main.instr[19:15];
  assign out_rs2     = r_main.instr[24:20];
  assign out_funct7  = r_main.instr[31:25];
  assign out_imm     = r_main.imm;
  assign out_fmt     = r_main.fmt;
  assign out_illegal = r_main.ill;

endmodule
